// File: rtl/des_pkg.sv
// Shared Triple DES definitions: block and byte widths, the block type,
// and the state type for the input block packer.
package des_pkg;

    localparam int BLOCK_W = 64;
    localparam int BYTE_W  = 8;

    typedef logic [BLOCK_W-1:0] des_block_t;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } pack_state_t;

endpackage

// File: rtl/input_block_packer_if.sv
// Byte-in / block-out bundle of the input block packer.
// The slave modport is the packer; the master modport is its environment.
interface input_block_packer_if #(
    parameter int BYTE_W          = 8,
    parameter int BYTES_PER_BLOCK = 8,
    parameter int CNT_W           = $clog2(BYTES_PER_BLOCK) + 1
);

    logic [BYTE_W-1:0]                 rx_data;
    logic                              rx_valid;
    logic                              rx_ready;
    logic                              frame_abort;
    logic                              clear_err;
    logic [BYTE_W*BYTES_PER_BLOCK-1:0] block_data;
    logic                              block_valid;
    logic                              block_ready;
    logic [CNT_W-1:0]                  byte_count;
    logic                              overrun;

    modport slave (
        input  rx_data, rx_valid, frame_abort, clear_err, block_ready,
        output rx_ready, block_data, block_valid, byte_count, overrun
    );

    modport master (
        output rx_data, rx_valid, frame_abort, clear_err, block_ready,
        input  rx_ready, block_data, block_valid, byte_count, overrun
    );

endinterface

// File: rtl/input_block_packer.sv
// Packs bytes from the I2C slave receive path into one block for the
// Triple DES datapath. The first byte received lands in the MSBs. A completed
// block is held until the consumer takes it; bytes arriving while the block
// is held and not being taken are dropped and flagged as an overrun.
module input_block_packer
    import des_pkg::pack_state_t, des_pkg::COLLECT, des_pkg::FULL;
#(
    parameter int BYTE_W          = 8,
    parameter int BYTES_PER_BLOCK = 8,
    parameter int CNT_W           = $clog2(BYTES_PER_BLOCK) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input_block_packer_if.slave   bus
);

    localparam int BLK_W = BYTE_W * BYTES_PER_BLOCK;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES_PER_BLOCK - 1);

    pack_state_t       state_reg, state_next;
    logic [BLK_W-1:0]  shreg_reg, shreg_next;
    logic [BLK_W-1:0]  block_reg, block_next;
    logic              valid_reg, valid_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              ovr_reg, ovr_next;
    logic              dropped;
    logic [BLK_W-1:0]  shift_in;
    logic [BLK_W-1:0]  first_byte;

    // Partial block shifted up one byte lane with the new byte in the LSBs;
    // written per lane so a single-byte block needs no special slicing.
    generate
        for (genvar gi = 0; gi < BYTES_PER_BLOCK; gi++) begin : g_lane
            if (gi == 0) begin : g_first
                assign shift_in[BYTE_W-1:0] = bus.rx_data;
            end else begin : g_rest
                assign shift_in[gi*BYTE_W +: BYTE_W] = shreg_reg[(gi-1)*BYTE_W +: BYTE_W];
            end
        end
    endgenerate

    assign first_byte = BLK_W'(bus.rx_data);

    // A held block frees the byte path only in the cycle it is being consumed.
    assign bus.rx_ready = (state_reg == COLLECT) | bus.block_ready;

    // Next-state logic for the collector, the held block and the error flag.
    always_comb begin
        state_next = state_reg;
        shreg_next = shreg_reg;
        block_next = block_reg;
        valid_next = valid_reg;
        cnt_next   = cnt_reg;
        dropped    = 1'b0;
        case (state_reg)
            COLLECT: begin
                if (bus.frame_abort) begin
                    shreg_next = '0;
                    cnt_next   = '0;
                end else if (bus.rx_valid) begin
                    shreg_next = shift_in;
                    cnt_next   = cnt_reg + 1'b1;
                    if (cnt_reg == CNT_LAST) begin
                        block_next = shift_in;
                        valid_next = 1'b1;
                        state_next = FULL;
                    end
                end
            end
            FULL: begin
                if (bus.block_ready) begin
                    state_next = COLLECT;
                    valid_next = 1'b0;
                    shreg_next = '0;
                    cnt_next   = '0;
                    // A byte arriving during handoff starts the next block.
                    if (bus.rx_valid && !bus.frame_abort) begin
                        shreg_next = first_byte;
                        cnt_next   = CNT_W'(1);
                        if (BYTES_PER_BLOCK == 1) begin
                            block_next = first_byte;
                            valid_next = 1'b1;
                            state_next = FULL;
                        end
                    end
                end else if (bus.rx_valid) begin
                    dropped = 1'b1;
                end
            end
            default: state_next = COLLECT;
        endcase
        // Sticky; a new drop beats a simultaneous clear.
        ovr_next = dropped | (ovr_reg & ~bus.clear_err);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= COLLECT;
            shreg_reg <= '0;
            block_reg <= '0;
            valid_reg <= 1'b0;
            cnt_reg   <= '0;
            ovr_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            shreg_reg <= shreg_next;
            block_reg <= block_next;
            valid_reg <= valid_next;
            cnt_reg   <= cnt_next;
            ovr_reg   <= ovr_next;
        end
    end

    assign bus.block_data  = block_reg;
    assign bus.block_valid = valid_reg;
    assign bus.byte_count  = cnt_reg;
    assign bus.overrun     = ovr_reg;

endmodule

// File: tb/tb_input_block_packer.sv
// Self-checking bench for input_block_packer: directed scenarios plus a
// randomized run compared against a byte-queue reference model.
module tb_input_block_packer;
    import des_pkg::des_block_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    // Reference model: bytes of the current block in arrival order, the held
    // block, and the sticky error flag.
    logic [7:0] m_q[$];
    logic       m_full;
    des_block_t m_block;
    logic       m_ovr;

    input_block_packer_if #(.BYTE_W(8), .BYTES_PER_BLOCK(8)) bus ();

    input_block_packer #(.BYTE_W(8), .BYTES_PER_BLOCK(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic des_block_t pack_queue();
        des_block_t v = '0;
        for (int i = 0; i < m_q.size(); i++) v = (v << 8) | des_block_t'(m_q[i]);
        return v;
    endfunction

    task automatic drive(input logic rv, input logic [7:0] rd, input logic br,
                         input logic fa, input logic ce, input logic r);
        bus.rx_valid    = rv;
        bus.rx_data     = rd;
        bus.block_ready = br;
        bus.frame_abort = fa;
        bus.clear_err   = ce;
        rst             = r;
    endtask

    task automatic model_update();
        logic dropped;
        dropped = 1'b0;
        if (rst) begin
            m_q.delete();
            m_full  = 1'b0;
            m_block = '0;
            m_ovr   = 1'b0;
        end else begin
            if (!m_full) begin
                if (bus.frame_abort) m_q.delete();
                else if (bus.rx_valid) begin
                    m_q.push_back(bus.rx_data);
                    if (m_q.size() == 8) begin
                        m_block = pack_queue();
                        m_full  = 1'b1;
                    end
                end
            end else if (bus.block_ready) begin
                m_full = 1'b0;
                m_q.delete();
                if (bus.rx_valid && !bus.frame_abort) m_q.push_back(bus.rx_data);
            end else if (bus.rx_valid) begin
                dropped = 1'b1;
            end
            m_ovr = dropped || (m_ovr && !bus.clear_err);
        end
    endtask

    task automatic clk_edge();
        @(posedge clk);
        model_update();
        #1;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step(input logic rv, input logic [7:0] rd, input logic br,
                        input logic fa, input logic ce, input logic r);
        drive(rv, rd, br, fa, ce, r);
        clk_edge();
    endtask

    task automatic test_reset();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (bus.block_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus.block_valid); else n_pass++;
        n_checks++; if (bus.byte_count !== 4'd0) $display("FAIL reset_count: got %0d expected 0", bus.byte_count); else n_pass++;
        n_checks++; if (bus.overrun !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", bus.overrun); else n_pass++;
        n_checks++; if (bus.rx_ready !== 1'b1) $display("FAIL reset_rx_ready: got %b expected 1", bus.rx_ready); else n_pass++;
        n_checks++; if (bus.block_data !== 64'h0) $display("FAIL reset_data: got %h expected 0", bus.block_data); else n_pass++;
        $display("reset: valid=%b count=%0d overrun=%b", bus.block_valid, bus.byte_count, bus.overrun);
    endtask

    task automatic test_fill_block();
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
            if (i == 7) begin
                n_checks++; if (bus.block_valid !== 1'b0) $display("FAIL fill_valid_early: got %b expected 0", bus.block_valid); else n_pass++;
                n_checks++; if (bus.byte_count !== 4'd7) $display("FAIL fill_count7: got %0d expected 7", bus.byte_count); else n_pass++;
            end
        end
        n_checks++; if (bus.block_valid !== 1'b1) $display("FAIL fill_valid: got %b expected 1", bus.block_valid); else n_pass++;
        n_checks++; if (bus.block_data !== 64'h0102030405060708) $display("FAIL fill_data: got %h expected 0102030405060708", bus.block_data); else n_pass++;
        n_checks++; if (bus.byte_count !== 4'd8) $display("FAIL fill_count: got %0d expected 8", bus.byte_count); else n_pass++;
        n_checks++; if (bus.rx_ready !== 1'b0) $display("FAIL fill_rx_ready: got %b expected 0", bus.rx_ready); else n_pass++;
        $display("fill: data=%h valid=%b count=%0d", bus.block_data, bus.block_valid, bus.byte_count);
    endtask

    task automatic test_handoff_idle();
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        n_checks++; if (bus.rx_ready !== 1'b1) $display("FAIL handoff_rx_ready: got %b expected 1", bus.rx_ready); else n_pass++;
        clk_edge();
        n_checks++; if (bus.block_valid !== 1'b0) $display("FAIL handoff_valid: got %b expected 0", bus.block_valid); else n_pass++;
        n_checks++; if (bus.byte_count !== 4'd0) $display("FAIL handoff_count: got %0d expected 0", bus.byte_count); else n_pass++;
        n_checks++; if (bus.block_data !== 64'h0102030405060708) $display("FAIL handoff_data: got %h expected 0102030405060708", bus.block_data); else n_pass++;
        $display("handoff_idle: valid=%b count=%0d data=%h", bus.block_valid, bus.byte_count, bus.block_data);
    endtask

    task automatic test_handoff_with_byte();
        for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++; if (bus.block_valid !== 1'b0) $display("FAIL hwb_valid: got %b expected 0", bus.block_valid); else n_pass++;
        n_checks++; if (bus.byte_count !== 4'd1) $display("FAIL hwb_count: got %0d expected 1", bus.byte_count); else n_pass++;
        for (int i = 0; i < 7; i++) step(1'b1, 8'(8'hBB + i), 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (bus.block_data !== 64'hAABBBCBDBEBFC0C1) $display("FAIL hwb_data: got %h expected AABBBCBDBEBFC0C1", bus.block_data); else n_pass++;
        n_checks++; if (bus.block_valid !== 1'b1) $display("FAIL hwb_valid2: got %b expected 1", bus.block_valid); else n_pass++;
        $display("handoff_with_byte: data=%h valid=%b", bus.block_data, bus.block_valid);
    endtask

    task automatic test_overrun();
        step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (bus.overrun !== 1'b1) $display("FAIL ovr_set: got %b expected 1", bus.overrun); else n_pass++;
        n_checks++; if (bus.block_data !== 64'hAABBBCBDBEBFC0C1) $display("FAIL ovr_data: got %h expected AABBBCBDBEBFC0C1", bus.block_data); else n_pass++;
        n_checks++; if (bus.byte_count !== 4'd8) $display("FAIL ovr_count: got %0d expected 8", bus.byte_count); else n_pass++;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (bus.overrun !== 1'b0) $display("FAIL ovr_clear: got %b expected 0", bus.overrun); else n_pass++;
        step(1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (bus.overrun !== 1'b1) $display("FAIL ovr_set_wins: got %b expected 1", bus.overrun); else n_pass++;
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++; if (bus.overrun !== 1'b1) $display("FAIL ovr_sticky: got %b expected 1", bus.overrun); else n_pass++;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        $display("overrun: overrun=%b count=%0d", bus.overrun, bus.byte_count);
    endtask

    task automatic test_abort();
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (bus.byte_count !== 4'd3) $display("FAIL abort_pre_count: got %0d expected 3", bus.byte_count); else n_pass++;
        step(1'b1, 8'h99, 1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (bus.byte_count !== 4'd0) $display("FAIL abort_count: got %0d expected 0", bus.byte_count); else n_pass++;
        n_checks++; if (bus.overrun !== 1'b0) $display("FAIL abort_overrun: got %b expected 0", bus.overrun); else n_pass++;
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (bus.block_data !== 64'h1011121314151617) $display("FAIL abort_data: got %h expected 1011121314151617", bus.block_data); else n_pass++;
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        $display("abort: data=%h count=%0d", bus.block_data, bus.byte_count);
    endtask

    task automatic test_reset_mid_block();
        for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (bus.byte_count !== 4'd5) $display("FAIL rmb_pre_count: got %0d expected 5", bus.byte_count); else n_pass++;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (bus.block_valid !== 1'b0) $display("FAIL rmb_valid: got %b expected 0", bus.block_valid); else n_pass++;
        n_checks++; if (bus.byte_count !== 4'd0) $display("FAIL rmb_count: got %0d expected 0", bus.byte_count); else n_pass++;
        n_checks++; if (bus.overrun !== 1'b0) $display("FAIL rmb_overrun: got %b expected 0", bus.overrun); else n_pass++;
        n_checks++; if (bus.rx_ready !== 1'b1) $display("FAIL rmb_rx_ready: got %b expected 1", bus.rx_ready); else n_pass++;
        n_checks++; if (bus.block_data !== 64'h0) $display("FAIL rmb_data: got %h expected 0", bus.block_data); else n_pass++;
        $display("reset_mid_block: valid=%b count=%0d overrun=%b", bus.block_valid, bus.byte_count, bus.overrun);
    endtask

    task automatic test_random();
        int errs_before;
        errs_before = n_checks - n_pass;
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 99) < 60, 8'($urandom_range(0, 255)),
                  $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 5,
                  $urandom_range(0, 99) < 10, $urandom_range(0, 999) < 5);
            #1;
            n_checks++; if (bus.rx_ready !== (!m_full || bus.block_ready)) $display("FAIL rnd_rx_ready cycle %0d: got %b expected %b", c, bus.rx_ready, !m_full || bus.block_ready); else n_pass++;
            clk_edge();
            n_checks++; if (bus.block_valid !== m_full) $display("FAIL rnd_valid cycle %0d: got %b expected %b", c, bus.block_valid, m_full); else n_pass++;
            n_checks++; if (bus.block_data !== m_block) $display("FAIL rnd_data cycle %0d: got %h expected %h", c, bus.block_data, m_block); else n_pass++;
            n_checks++; if (bus.byte_count !== 4'(m_q.size())) $display("FAIL rnd_count cycle %0d: got %0d expected %0d", c, bus.byte_count, m_q.size()); else n_pass++;
            n_checks++; if (bus.overrun !== m_ovr) $display("FAIL rnd_overrun cycle %0d: got %b expected %b", c, bus.overrun, m_ovr); else n_pass++;
        end
        $display("random: 3000 cycles, %0d new discrepancies", (n_checks - n_pass) - errs_before);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        m_full   = 1'b0;
        m_block  = '0;
        m_ovr    = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        test_reset();
        test_fill_block();
        test_handoff_idle();
        test_handoff_with_byte();
        test_overrun();
        test_abort();
        test_reset_mid_block();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
